pll_sync_launch: RTL and testbench

Fast-to-slow data launcher, the transmit-side counterpart of the fast/slow phase counter. It runs entirely in the fast clock domain and buffers fast-domain samples in a small FIFO. It uses the phase counter to launch one word per slow period onto registers that hold stable across the slow clock's rising edge. Typical placement: between the fast ADC/processing pipeline and slow-clock consumers such as the FT245 or USB output path.

---
 rtl/pll_sync_launch.sv | 151 +++++++++++++++
 tb/tb_pll_sync_launch.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pll_sync_launch.sv
`timescale 1ns/1ps
// pll_sync_launch
// Fast-domain launcher feeding a slower clock that is phase-locked to it.
// Samples are queued in a small FIFO. One word is launched per slow period,
// in the fast cycle where the phase counter equals LAUNCH. The launched word
// is held in dout_q across the slow rising edge, which is the ctr == 0 cycle.
// Launches happen only while the phase counter has been seen stepping
// continuously.
module pll_sync_launch #(
  parameter int RATIO  = 8,
  parameter int WIDTH  = 14,
  parameter int DEPTH  = 4,
  parameter int LAUNCH = RATIO / 2
) (
  input  logic                       fst_clk,
  input  logic                       rst_n,
  input  logic [$clog2(RATIO)-1:0]   ctr,
  input  logic [WIDTH-1:0]           di,
  input  logic                       di_valid,
  output logic                       di_ready,
  output logic [WIDTH-1:0]           dout,
  output logic                       dout_valid,
  output logic                       locked,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int CW = $clog2(RATIO);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int GW = CW + 1;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

  lock_state_t     state_q, state_d;
  logic [CW-1:0]   last_ctr_q;
  logic [GW-1:0]   good_cnt_q, good_cnt_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic            dout_valid_q, dout_valid_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic            step_ok;
  logic            locked_w;
  logic [PW-1:0]   level_w;
  logic            full_w;
  logic            push_w;
  logic            launch_w;
  logic            pop_w;

  // FIFO occupancy and handshake; di_ready ignores any same-cycle pop.
  always_comb begin
    level_w  = wr_ptr_q - rd_ptr_q;
    full_w   = (level_w == PW'(DEPTH));
    di_ready = rst_n & ~full_w;
    push_w   = di_valid & di_ready;
    locked_w = (state_q == LOCKED);
    launch_w = locked_w && (ctr == CW'(LAUNCH));
    pop_w    = launch_w && (level_w != '0);
  end

  // Lock tracker: needs RATIO consecutive correct steps to lock, and drops on any bad step.
  always_comb begin
    step_ok    = (ctr == CW'(last_ctr_q + 1'b1));
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    case (state_q)
      UNLOCKED: begin
        if (step_ok) begin
          if (good_cnt_q == GW'(RATIO - 1)) begin
            state_d    = LOCKED;
            good_cnt_d = '0;
          end else begin
            good_cnt_d = good_cnt_q + GW'(1);
          end
        end else begin
          good_cnt_d = '0;
        end
      end
      LOCKED: begin
        if (!step_ok) begin
          state_d    = UNLOCKED;
          good_cnt_d = '0;
        end
      end
      default: begin
        state_d    = UNLOCKED;
        good_cnt_d = '0;
      end
    endcase
  end

  // Pointer and launch register next-state; an empty launch clears valid but keeps dout.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    if (push_w) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (launch_w) begin
      if (pop_w) begin
        dout_d       = mem_q[rd_ptr_q[AW-1:0]];
        dout_valid_d = 1'b1;
        rd_ptr_d     = rd_ptr_q + PW'(1);
      end else begin
        dout_valid_d = 1'b0;
      end
    end else if (!locked_w) begin
      dout_valid_d = 1'b0;
    end
  end

  // State registers; reset discards queued data and drops the launch outputs at once.
  always_ff @(posedge fst_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= UNLOCKED;
      last_ctr_q   <= '0;
      good_cnt_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_ctr_q   <= ctr;
      good_cnt_q   <= good_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge fst_clk) begin
    if (push_w) begin
      mem_q[wr_ptr_q[AW-1:0]] <= di;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign locked     = locked_w;
  assign level      = level_w;

endmodule

// File: tb/tb_pll_sync_launch.sv
`timescale 1ns/1ps
// Directed bench for pll_sync_launch with RATIO=8, WIDTH=14, DEPTH=4, LAUNCH=4.
module tb_pll_sync_launch;

  localparam int RATIO  = 8;
  localparam int WIDTH  = 14;
  localparam int DEPTH  = 4;
  localparam int LAUNCH = 4;

  logic             fst_clk = 1'b0;
  logic             rst_n;
  logic [2:0]       ctr;
  logic [WIDTH-1:0] di;
  logic             di_valid;
  logic             di_ready;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             locked;
  logic [2:0]       level;

  int n_vec = 0;
  int n_err = 0;

  pll_sync_launch #(
    .RATIO(RATIO), .WIDTH(WIDTH), .DEPTH(DEPTH), .LAUNCH(LAUNCH)
  ) dut (
    .fst_clk(fst_clk), .rst_n(rst_n), .ctr(ctr), .di(di), .di_valid(di_valid),
    .di_ready(di_ready), .dout(dout), .dout_valid(dout_valid),
    .locked(locked), .level(level)
  );

  always #5 fst_clk = ~fst_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1);
  end

  task automatic edge1();
    @(posedge fst_clk);
    #1;
  endtask

  // One fast cycle: the edge ends the current ctr value, then ctr advances.
  task automatic step();
    edge1();
    ctr = ctr + 3'd1;
  endtask

  // Advance until the edge that ends the cycle with ctr == t has passed.
  task automatic run_to(input logic [2:0] t);
    logic [2:0] was;
    for (int i = 0; i < RATIO; i++) begin
      was = ctr;
      step();
      if (was == t) break;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ctr = 3'd0; di = '0; di_valid = 1'b0;
    #12;
    n_vec++; if (dout !== 14'h0)    begin n_err++; $display("FAIL reset_dout: got %h want 0000", dout); end
    n_vec++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL reset_dout_valid: got %b want 0", dout_valid); end
    n_vec++; if (locked !== 1'b0)   begin n_err++; $display("FAIL reset_locked: got %b want 0", locked); end
    n_vec++; if (level !== 3'd0)    begin n_err++; $display("FAIL reset_level: got %0d want 0", level); end
    n_vec++; if (di_ready !== 1'b0) begin n_err++; $display("FAIL reset_di_ready: got %b want 0", di_ready); end
    @(posedge fst_clk); #1;
    rst_n = 1'b1;
    #1;
    n_vec++; if (di_ready !== 1'b1) begin n_err++; $display("FAIL release_di_ready: got %b want 1", di_ready); end
    $display("reset: checked outputs during and after reset");
  endtask

  task automatic test_lock();
    repeat (8) step();
    n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL lock_after8: got %b want 0", locked); end
    step();
    n_vec++; if (locked !== 1'b1) begin n_err++; $display("FAIL lock_after9: got %b want 1", locked); end
    n_vec++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL lock_valid: got %b want 0", dout_valid); end
    $display("lock: locked=%b after 9 edges", locked);
  endtask

  task automatic test_single_word();
    di = 14'h155; di_valid = 1'b1;
    step();
    di_valid = 1'b0;
    n_vec++; if (level !== 3'd1) begin n_err++; $display("FAIL single_level: got %0d want 1", level); end
    step(); step();
    n_vec++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL single_early: got %b want 0", dout_valid); end
    step();
    n_vec++; if (dout !== 14'h155) begin n_err++; $display("FAIL single_dout: got %h want 0155", dout); end
    n_vec++; if (dout_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", dout_valid); end
    n_vec++; if (level !== 3'd0) begin n_err++; $display("FAIL single_level0: got %0d want 0", level); end
    run_to(3'd3);
    n_vec++; if (dout_valid !== 1'b1) begin n_err++; $display("FAIL single_hold: got %b want 1", dout_valid); end
    step();
    n_vec++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL single_empty_valid: got %b want 0", dout_valid); end
    n_vec++; if (dout !== 14'h155) begin n_err++; $display("FAIL single_empty_dout: got %h want 0155", dout); end
    $display("single: launched %h", dout);
  endtask

  task automatic test_backpressure();
    for (int w = 1; w <= 4; w++) begin
      di = WIDTH'(w); di_valid = 1'b1;
      step();
    end
    n_vec++; if (level !== 3'd4) begin n_err++; $display("FAIL bp_level_full: got %0d want 4", level); end
    n_vec++; if (di_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_low: got %b want 0", di_ready); end
    di = 14'd5;
    step(); step(); step();
    n_vec++; if (level !== 3'd4) begin n_err++; $display("FAIL bp_level_hold: got %0d want 4", level); end
    step();
    n_vec++; if (dout !== 14'd1) begin n_err++; $display("FAIL bp_dout: got %h want 0001", dout); end
    n_vec++; if (level !== 3'd3) begin n_err++; $display("FAIL bp_level_pop: got %0d want 3", level); end
    n_vec++; if (di_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_high: got %b want 1", di_ready); end
    step();
    di_valid = 1'b0;
    n_vec++; if (level !== 3'd4) begin n_err++; $display("FAIL bp_level_refill: got %0d want 4", level); end
    $display("backpressure: first launch %h", 14'd1);
  endtask

  task automatic test_order_rate();
    for (int i = 0; i < 6; i++) begin
      run_to(3'd4);
      n_vec++; if (dout !== WIDTH'(2 + i)) begin n_err++; $display("FAIL order_dout[%0d]: got %h want %h", i, dout, WIDTH'(2 + i)); end
      n_vec++; if (dout_valid !== 1'b1) begin n_err++; $display("FAIL order_valid[%0d]: got %b want 1", i, dout_valid); end
      n_vec++; if (level !== 3'd3) begin n_err++; $display("FAIL order_level[%0d]: got %0d want 3", i, level); end
      $display("order: period %0d launched %h", i, dout);
      di = WIDTH'(6 + i); di_valid = 1'b1;
      step();
      di_valid = 1'b0;
    end
  endtask

  task automatic test_phase_glitch();
    run_to(3'd2);
    edge1();
    ctr = 3'd6;
    edge1();
    n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL glitch_unlock: got %b want 0", locked); end
    ctr = 3'd7;
    step();
    n_vec++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL glitch_valid: got %b want 0", dout_valid); end
    run_to(3'd4);
    n_vec++; if (level !== 3'd4) begin n_err++; $display("FAIL glitch_nopop: got %0d want 4", level); end
    n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL glitch_still_unlocked: got %b want 0", locked); end
    n_vec++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL glitch_valid_low: got %b want 0", dout_valid); end
    run_to(3'd6);
    n_vec++; if (locked !== 1'b1) begin n_err++; $display("FAIL glitch_relock: got %b want 1", locked); end
    run_to(3'd4);
    n_vec++; if (dout !== 14'd8) begin n_err++; $display("FAIL glitch_dout0: got %h want 0008", dout); end
    n_vec++; if (dout_valid !== 1'b1) begin n_err++; $display("FAIL glitch_valid0: got %b want 1", dout_valid); end
    run_to(3'd4);
    n_vec++; if (dout !== 14'd9) begin n_err++; $display("FAIL glitch_dout1: got %h want 0009", dout); end
    n_vec++; if (level !== 3'd2) begin n_err++; $display("FAIL glitch_level: got %0d want 2", level); end
    $display("glitch: relocked, resumed with %h", dout);
  endtask

  task automatic test_async_reset();
    di = 14'd12; di_valid = 1'b1;
    step();
    di_valid = 1'b0;
    n_vec++; if (level !== 3'd3) begin n_err++; $display("FAIL areset_pre_level: got %0d want 3", level); end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++; if (level !== 3'd0) begin n_err++; $display("FAIL areset_level: got %0d want 0", level); end
    n_vec++; if (dout !== 14'h0) begin n_err++; $display("FAIL areset_dout: got %h want 0000", dout); end
    n_vec++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL areset_valid: got %b want 0", dout_valid); end
    n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL areset_locked: got %b want 0", locked); end
    n_vec++; if (di_ready !== 1'b0) begin n_err++; $display("FAIL areset_ready: got %b want 0", di_ready); end
    @(posedge fst_clk); #1;
    rst_n = 1'b1;
    ctr = 3'd0;
    repeat (9) step();
    n_vec++; if (locked !== 1'b1) begin n_err++; $display("FAIL areset_relock: got %b want 1", locked); end
    run_to(3'd4);
    n_vec++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL areset_discard_valid: got %b want 0", dout_valid); end
    n_vec++; if (level !== 3'd0) begin n_err++; $display("FAIL areset_discard_level: got %0d want 0", level); end
    $display("async_reset: cleared without clock, FIFO discarded");
  endtask

  initial begin
    test_reset();
    test_lock();
    test_single_word();
    test_backpressure();
    test_order_rate();
    test_phase_glitch();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
